// File: rtl/bcd_display_feeder_if.sv
// Handshake and digit bus between a binary source, the BCD feeder and the scan multiplexer.
interface bcd_display_feeder_if #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  // Requester side: issues conversions, observes the result.
  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow
  );

  // Converter side.
  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output overflow
  );

endinterface

// File: rtl/bcd_display_feeder.sv
// Iterative double-dabble binary-to-BCD converter that holds its last result
// stable for a seven-segment scan multiplexer, saturating to all nines.
module bcd_display_feeder #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_display_feeder_if.slave  bus
);

  localparam int unsigned SCR_W = 4 * DIGITS;
  localparam int unsigned CAT_W = SCR_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int unsigned    MAX_VAL = pow10(DIGITS) - 1;
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SCR_W-1:0]   adj_c;
  logic [CAT_W-1:0]   cat_c;
  logic               last_c;

  // Add 3 to every digit >= 5, each digit confined to its own nibble.
  function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Adjusted scratch shifted together with the remaining binary bits.
  always_comb begin
    adj_c  = add3(scr_q);
    cat_c  = {adj_c, bin_q} << 1;
    last_c = (cnt_q == CNT_W'(1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_c)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; start is only honoured in IDLE.
  always_comb begin
    bin_d  = bin_q;
    scr_d  = scr_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.bin_in > MAX_BIN) begin
            bin_d  = MAX_BIN;
            pend_d = 1'b1;
          end else begin
            bin_d  = bus.bin_in;
            pend_d = 1'b0;
          end
          scr_d  = '0;
          cnt_d  = CNT_W'(BIN_W);
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        scr_d = cat_c[CAT_W-1:BIN_W];
        bin_d = cat_c[BIN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (last_c) begin
          bcd_d  = cat_c[CAT_W-1:BIN_W];
          ovf_d  = pend_q;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      scr_q  <= scr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Self-checking bench for bcd_display_feeder: directed plan plus random values
// compared against a decimal-arithmetic reference.
module tb_bcd_display_feeder;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;

  logic clk;
  logic rst_n;

  bcd_display_feeder_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus_if ();

  bcd_display_feeder #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] prev_bcd;
  logic        prev_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: saturate to 9999, then peel decimal digits with div/mod.
  function automatic logic [15:0] bcd_ref(input int unsigned v);
    int unsigned s;
    int unsigned p;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((s / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic start_pulse(input int unsigned v);
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.bin_in = BIN_W'(v);
    @(posedge clk);
    #1;
    bus_if.start  = 1'b0;
    bus_if.bin_in = BIN_W'($urandom);
  endtask

  // Called 1 time unit after the accepting edge; follows the conversion to done.
  task automatic finish_conv(input string tag, input int unsigned v, input int inject_at);
    int          lat;
    int          bc;
    logic        stable;
    logic [15:0] exp_b;
    logic        exp_o;
    exp_b  = bcd_ref(v);
    exp_o  = (v > 9999);
    lat    = 0;
    bc     = 0;
    stable = 1'b1;
    if (bus_if.busy === 1'b1) bc++;
    while (bus_if.done !== 1'b1 && lat < 40) begin
      if (lat == inject_at) begin
        bus_if.start  = 1'b1;
        bus_if.bin_in = BIN_W'(777);
      end else begin
        bus_if.start  = 1'b0;
        bus_if.bin_in = BIN_W'($urandom);
      end
      if (bus_if.bcd_out !== prev_bcd || bus_if.overflow !== prev_ovf) stable = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (bus_if.busy === 1'b1) bc++;
    end
    bus_if.start = 1'b0;
    check($sformatf("%s_latency", tag), 32'(lat), 32'd14);
    check($sformatf("%s_busy_cycles", tag), 32'(bc), 32'd14);
    check($sformatf("%s_held_stable", tag), 32'(stable), 32'd1);
    check($sformatf("%s_bcd", tag), 32'(bus_if.bcd_out), 32'(exp_b));
    check($sformatf("%s_ovf", tag), 32'(bus_if.overflow), 32'(exp_o));
    prev_bcd = exp_b;
    prev_ovf = exp_o;
  endtask

  task automatic after_done(input string tag);
    @(posedge clk);
    #1;
    check($sformatf("%s_done_drop", tag), 32'(bus_if.done), 32'd0);
    check($sformatf("%s_idle", tag), 32'(bus_if.busy), 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int d;
    int b;
    d = 0;
    b = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus_if.done === 1'b1) d++;
      if (bus_if.busy === 1'b1) b++;
    end
    check($sformatf("%s_no_done", tag), 32'(d), 32'd0);
    check($sformatf("%s_no_busy", tag), 32'(b), 32'd0);
  endtask

  int unsigned basic_v[3] = '{0, 1234, 9999};
  int unsigned sat_v[3]   = '{10000, 16383, 42};

  initial begin
    int unsigned v;
    rst_n         = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.bin_in = '0;
    prev_bcd      = '0;
    prev_ovf      = 1'b0;

    // Reset state, then a long idle stretch.
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", 32'(bus_if.bcd_out), 32'h0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_ovf", 32'(bus_if.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("idle", 20);
    check("idle_bcd", 32'(bus_if.bcd_out), 32'h0);
    check("idle_ovf", 32'(bus_if.overflow), 32'd0);

    // Basic conversions.
    for (int i = 0; i < 3; i++) begin
      start_pulse(basic_v[i]);
      finish_conv($sformatf("basic%0d", i), basic_v[i], -1);
      after_done($sformatf("basic%0d", i));
    end

    // Saturation and recovery.
    for (int i = 0; i < 3; i++) begin
      start_pulse(sat_v[i]);
      finish_conv($sformatf("sat%0d", i), sat_v[i], -1);
      after_done($sformatf("sat%0d", i));
    end

    // Start while busy is ignored and not queued.
    start_pulse(555);
    finish_conv("busy_start", 555, 5);
    after_done("busy_start");
    watch_quiet("busy_start_after", 30);
    check("busy_start_bcd", 32'(bus_if.bcd_out), 32'h0555);

    // Back-to-back: start held through the done cycle.
    start_pulse(100);
    finish_conv("b2b1", 100, -1);
    bus_if.start  = 1'b1;
    bus_if.bin_in = BIN_W'(200);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    check("b2b_rebusy", 32'(bus_if.busy), 32'd1);
    check("b2b_done_drop", 32'(bus_if.done), 32'd0);
    check("b2b_bcd_held", 32'(bus_if.bcd_out), 32'h0100);
    finish_conv("b2b2", 200, -1);
    after_done("b2b2");

    // Randomized conversions, biased around the saturation boundary.
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) v = $urandom_range(9990, 10010);
      else            v = $urandom_range(0, 16383);
      start_pulse(v);
      finish_conv($sformatf("rand%0d_v%0d", i, v), v, -1);
      after_done($sformatf("rand%0d", i));
    end

    // Leave overflow set so the reset clear is observable.
    start_pulse(12000);
    finish_conv("presat", 12000, -1);
    after_done("presat");

    // Reset mid-conversion clears everything asynchronously.
    start_pulse(8765);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_bcd", 32'(bus_if.bcd_out), 32'h0);
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    check("midrst_done", 32'(bus_if.done), 32'd0);
    check("midrst_ovf", 32'(bus_if.overflow), 32'd0);
    prev_bcd = '0;
    prev_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("post_rst", 20);
    start_pulse(31);
    finish_conv("post_rst_conv", 31, -1);
    after_done("post_rst_conv");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
